// File: rtl/store_pkg.sv
// store_pkg: shared definitions for the store path.
// Holds the store type codes, the output FSM state encoding and the
// size decode used both at request accept and at beat formatting.
package store_pkg;

    // Store type codes as presented on i_type; every other code is illegal.
    localparam logic [2:0] ST_BYTE = 3'b000;
    localparam logic [2:0] ST_HALF = 3'b001;
    localparam logic [2:0] ST_WORD = 3'b011;

    // Output sequencer states. BEAT1 is only reachable when split support is built in.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_e;

    // Store size in bytes for a type code; 0 marks an illegal code.
    function automatic logic [2:0] st_size(input logic [2:0] t);
        logic [2:0] s;
        case (t)
            ST_BYTE: s = 3'd1;
            ST_HALF: s = 3'd2;
            ST_WORD: s = 3'd4;
            default: s = 3'd0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/store_fifo.sv
// store_fifo: synchronous FIFO with first-word-fall-through read port.
// o_rdata always shows the oldest entry; it is meaningful while !o_empty.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// Storage is not reset; only the pointers are.
module store_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW:0]      wr_q, wr_d;
    logic [PW:0]      rd_q, rd_d;
    logic             do_push, do_pop;

    // Qualify requests against the current fill state and advance pointers.
    always_comb begin
        do_push = i_push && !o_full;
        do_pop  = i_pop && !o_empty;
        wr_d    = do_push ? wr_q + (PW+1)'(1) : wr_q;
        rd_d    = do_pop  ? rd_q + (PW+1)'(1) : rd_q;
    end

    // Pointer registers; reset flushes the queue.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Entry storage, written at the tail.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wr_q[PW-1:0]] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[rd_q[PW-1:0]];
    assign o_empty = (wr_q == rd_q);
    assign o_full  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);

endmodule

// File: rtl/store_unit.sv
// store_unit: store path from the EX/MEM register to the data-memory write port.
// Requests are checked for type legality, queued in store_fifo as
// {type, addr, data}, then formatted into lane-aligned beats with byte
// enables by a three-process output sequencer.
// Build option STORE_SPLIT_EN: when defined, stores crossing a word boundary
// are issued as two consecutive beats; when undefined they are dropped at
// accept with an o_align_err pulse and the second-beat logic is not built.
module store_unit
    import store_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [2:0]          i_type,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [DATA_W-1:0]   i_data,
    output logic                o_mem_valid,
    input  logic                i_mem_ready,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_be,
    output logic                o_type_err,
    output logic                o_align_err,
    output logic                o_empty
);

    localparam int NB   = DATA_W / 8;
    localparam int OFFW = $clog2(NB);
    localparam int EW   = 3 + ADDR_W + DATA_W;
`ifdef STORE_SPLIT_EN
    // Formatting spans two words so the spill-over lanes land in the upper half.
    localparam int FL = 2 * NB;
`else
    localparam int FL = NB;
`endif
    localparam int FW = 8 * FL;

    // ---------------- accept side ----------------
    logic            accept;
    logic            legal_in;
    logic [2:0]      size_in;
    logic            push;
    logic            type_err_d, type_err_q;
    logic            fifo_full, fifo_empty;
    logic [EW-1:0]   head;
`ifndef STORE_SPLIT_EN
    logic [OFFW-1:0] off_in;
    logic            cross_in;
    logic            align_err_d, align_err_q;
`endif

    // Classify the incoming request and decide whether it enters the queue.
    always_comb begin
        size_in    = st_size(i_type);
        legal_in   = (size_in != 3'd0);
        accept     = i_valid && o_ready;
        type_err_d = accept && !legal_in;
`ifdef STORE_SPLIT_EN
        push       = accept && legal_in;
`else
        off_in      = i_addr[OFFW-1:0];
        cross_in    = (int'(off_in) + int'(size_in)) > NB;
        push        = accept && legal_in && !cross_in;
        align_err_d = accept && legal_in && cross_in;
`endif
    end

    // o_ready is taken from the registered fill state, before any same-cycle pop.
    assign o_ready = !fifo_full;

    // ---------------- queue ----------------
    logic pop;

    store_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (push),
        .i_wdata ({i_type, i_addr, i_data}),
        .i_pop   (pop),
        .o_rdata (head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    // ---------------- head formatting ----------------
    logic [2:0]        h_type;
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_data;
    logic [DATA_W-1:0] h_dmask;
    logic [2:0]        h_size;
    logic [OFFW-1:0]   h_off;
    logic [ADDR_W-1:0] h_base;
    logic [FL-1:0]     h_be;
    logic [FW-1:0]     h_wd;

    // Place the head store's bytes onto memory lanes; upper lanes spill into beat1.
    always_comb begin
        {h_type, h_addr, h_data} = head;
        h_size  = st_size(h_type);
        h_off   = h_addr[OFFW-1:0];
        h_base  = {h_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
        h_dmask = '0;
        for (int i = 0; i < NB; i++) begin
            if (i < int'(h_size)) begin
                h_dmask[8*i +: 8] = h_data[8*i +: 8];
            end
        end
        h_wd = FW'(h_dmask) << (8 * int'(h_off));
        h_be = '0;
        for (int j = 0; j < FL; j++) begin
            h_be[j] = (j >= int'(h_off)) && (j < int'(h_off) + int'(h_size));
        end
    end

    // ---------------- output sequencer ----------------
    state_e            state_q, state_d;
    logic              xfer;
    logic              empty_d, empty_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [NB-1:0]     mem_be_q;
`ifdef STORE_SPLIT_EN
    logic              load1;
    logic              cross_q;
    logic [ADDR_W-1:0] b1_addr_q;
    logic [DATA_W-1:0] b1_wdata_q;
    logic [NB-1:0]     b1_be_q;
`endif

    assign o_mem_valid = (state_q != IDLE);
    assign xfer        = o_mem_valid && i_mem_ready;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a crossing store always follows beat0 with its beat1.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = BEAT0;
            end
            BEAT0: begin
                if (xfer) begin
`ifdef STORE_SPLIT_EN
                    if (cross_q) state_d = BEAT1;
                    else
`endif
                    state_d = fifo_empty ? IDLE : BEAT0;
                end
            end
`ifdef STORE_SPLIT_EN
            BEAT1: begin
                if (xfer) state_d = fifo_empty ? IDLE : BEAT0;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Sequencer outputs: when to pop the queue and when to load the second beat.
    always_comb begin
        pop = 1'b0;
`ifdef STORE_SPLIT_EN
        load1 = 1'b0;
`endif
        case (state_q)
            IDLE: pop = !fifo_empty;
            BEAT0: begin
                if (xfer) begin
`ifdef STORE_SPLIT_EN
                    if (cross_q) load1 = 1'b1;
                    else
`endif
                    pop = !fifo_empty;
                end
            end
`ifdef STORE_SPLIT_EN
            BEAT1: begin
                if (xfer) pop = !fifo_empty;
            end
`endif
            default: pop = 1'b0;
        endcase
        // Drained once the sequencer settles in IDLE with nothing arriving this edge.
        empty_d = (state_d == IDLE) && !push;
    end

    // Beat output register: holds steady until the memory takes the beat.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else if (pop) begin
            mem_addr_q  <= h_base;
            mem_wdata_q <= h_wd[DATA_W-1:0];
            mem_be_q    <= h_be[NB-1:0];
        end
`ifdef STORE_SPLIT_EN
        else if (load1) begin
            mem_addr_q  <= b1_addr_q;
            mem_wdata_q <= b1_wdata_q;
            mem_be_q    <= b1_be_q;
        end
`endif
    end

`ifdef STORE_SPLIT_EN
    // Crossing flag for the beat in flight; reset drops any pending second beat.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cross_q <= 1'b0;
        end else if (pop) begin
            cross_q <= |h_be[FL-1:NB];
        end
    end

    // Second-beat staging, captured together with beat0 since the head is popped.
    always_ff @(posedge i_clk) begin
        if (pop) begin
            b1_addr_q  <= h_base + ADDR_W'(NB);
            b1_wdata_q <= h_wd[FW-1:DATA_W];
            b1_be_q    <= h_be[FL-1:NB];
        end
    end
`endif

    // Status flags: single-cycle error pulses and the registered drain indication.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            type_err_q <= 1'b0;
            empty_q    <= 1'b1;
        end else begin
            type_err_q <= type_err_d;
            empty_q    <= empty_d;
        end
    end

`ifdef STORE_SPLIT_EN
    assign o_align_err = 1'b0;
`else
    // Crossing-store rejection pulse.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            align_err_q <= 1'b0;
        end else begin
            align_err_q <= align_err_d;
        end
    end

    assign o_align_err = align_err_q;
`endif

    assign o_type_err  = type_err_q;
    assign o_empty     = empty_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_mem_be    = mem_be_q;

endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: directed and randomized bench for store_unit (32-bit data, DEPTH 4).
// A queue of expected memory beats is built from each accepted request using
// plain arithmetic on size and offset; a negedge process compares every
// meaningful DUT output against it. Honors STORE_SPLIT_EN like the design.
module tb_store_unit;

    localparam int DEPTH = 4;
`ifdef STORE_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_reset, i_valid, i_mem_ready;
    logic [2:0]  i_type;
    logic [31:0] i_addr, i_data;
    logic        o_ready, o_mem_valid, o_type_err, o_align_err, o_empty;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_be;

    always #5 i_clk = ~i_clk;

    store_unit #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_type      (i_type),
        .i_addr      (i_addr),
        .i_data      (i_data),
        .o_mem_valid (o_mem_valid),
        .i_mem_ready (i_mem_ready),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_mem_be    (o_mem_be),
        .o_type_err  (o_type_err),
        .o_align_err (o_align_err),
        .o_empty     (o_empty)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        bit          last;
    } beat_t;

    beat_t q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    bit    chk_en   = 1'b0;
    bit    exp_type = 1'b0;
    bit    exp_align = 1'b0;

    function automatic void chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Expected beats for one accepted request, from size/offset arithmetic.
    function automatic void model_accept(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
        int          s, off;
        logic [63:0] m;
        logic [7:0]  be;
        logic [31:0] base;
        beat_t       b;
        case (t)
            3'b000:  s = 1;
            3'b001:  s = 2;
            3'b011:  s = 4;
            default: s = 0;
        endcase
        if (s == 0) begin
            exp_type = 1'b1;
            return;
        end
        off  = int'(a[1:0]);
        m    = {32'h0, d} & ((64'd1 << (8 * s)) - 64'd1);
        m    = m << (8 * off);
        be   = 8'(((1 << s) - 1) << off);
        base = {a[31:2], 2'b00};
        if (off + s > 4 && !SPLIT) begin
            exp_align = 1'b1;
            return;
        end
        b.addr = base; b.wdata = m[31:0]; b.be = be[3:0]; b.last = (off + s <= 4);
        q.push_back(b);
        if (off + s > 4) begin
            b.addr = base + 32'd4; b.wdata = m[63:32]; b.be = be[7:4]; b.last = 1'b1;
            q.push_back(b);
        end
    endfunction

    // Per-cycle compare against the model, then advance the model for the coming edge.
    always @(negedge i_clk) begin
        if (chk_en) begin
            int nst;
            nst = 0;
            foreach (q[k]) if (q[k].last) nst++;
            chk1("o_empty", o_empty, q.size() == 0);
            chk1("o_type_err", o_type_err, exp_type);
            chk1("o_align_err", o_align_err, exp_align);
            if (nst < DEPTH) chk1("o_ready_free", o_ready, 1'b1);
            else if (nst > DEPTH) chk1("o_ready_full", o_ready, 1'b0);
            if (q.size() == 0) chk1("valid_when_idle", o_mem_valid, 1'b0);
            else if (o_mem_valid) begin
                chk32("beat_addr", o_mem_addr, q[0].addr);
                chk32("beat_wdata", o_mem_wdata, q[0].wdata);
                chk32("beat_be", 32'(o_mem_be), 32'(q[0].be));
            end
            exp_type  = 1'b0;
            exp_align = 1'b0;
            if (i_reset) begin
                q.delete();
            end else begin
                if (o_mem_valid && i_mem_ready && q.size() > 0) void'(q.pop_front());
                if (i_valid && o_ready) model_accept(i_type, i_addr, i_data);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    // Present one request and hold it until accepted; returns 1ns after the accepting edge.
    task automatic send(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
        int k;
        i_valid = 1'b1; i_type = t; i_addr = a; i_data = d;
        k = 0;
        @(negedge i_clk);
        while (!o_ready && k < 50) begin
            @(negedge i_clk);
            k++;
        end
        if (!o_ready) chk1("send_accept_timeout", o_ready, 1'b1);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic chk_beat(input string name, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        chk1({name, "_valid"}, o_mem_valid, 1'b1);
        chk32({name, "_addr"}, o_mem_addr, a);
        chk32({name, "_be"}, 32'(o_mem_be), 32'(be));
        chk32({name, "_wdata"}, o_mem_wdata, wd);
    endtask

    initial begin
        i_reset = 1'b1; i_valid = 1'b0; i_type = 3'b000;
        i_addr = '0; i_data = '0; i_mem_ready = 1'b0;
        step(3);
        chk1("rst_ready", o_ready, 1'b1);
        chk1("rst_empty", o_empty, 1'b1);
        chk1("rst_valid", o_mem_valid, 1'b0);
        chk1("rst_type_err", o_type_err, 1'b0);
        chk1("rst_align_err", o_align_err, 1'b0);
        chk32("rst_addr", o_mem_addr, 32'h0);
        chk32("rst_wdata", o_mem_wdata, 32'h0);
        chk32("rst_be", 32'(o_mem_be), 32'h0);
        i_reset = 1'b0;
        chk_en = 1'b1;
        i_mem_ready = 1'b1;
        step(3);

        // Byte store into lane 3, with first-beat latency.
        send(3'b000, 32'h0000_1003, 32'hAABB_CCDD);
        chk1("byte_latency_e", o_mem_valid, 1'b0);
        step(1);
        chk_beat("byte", 32'h0000_1000, 4'b1000, 32'hDD00_0000);
        step(3);

        // Half store into the upper half.
        send(3'b001, 32'h0000_2002, 32'h0000_1234);
        step(1);
        chk_beat("half", 32'h0000_2000, 4'b1100, 32'h1234_0000);
        step(3);

        // Non-crossing misaligned half.
        send(3'b001, 32'h0000_5001, 32'hFFFF_BEEF);
        step(1);
        chk_beat("half_mis", 32'h0000_5000, 4'b0110, 32'h00BE_EF00);
        step(3);

        // Word store crossing a word boundary.
        send(3'b011, 32'h0000_3001, 32'h1122_3344);
`ifdef STORE_SPLIT_EN
        step(1);
        chk_beat("cross_b0", 32'h0000_3000, 4'b1110, 32'h2233_4400);
        step(1);
        chk_beat("cross_b1", 32'h0000_3004, 4'b0001, 32'h0000_0011);
`else
        chk1("cross_align_pulse", o_align_err, 1'b1);
        chk1("cross_no_beat", o_mem_valid, 1'b0);
        step(1);
        chk1("cross_align_clear", o_align_err, 1'b0);
        chk1("cross_no_beat2", o_mem_valid, 1'b0);
`endif
        step(3);

        // Illegal type, then a legal store right behind it.
        send(3'b010, 32'h0000_4000, 32'h0000_0055);
        chk1("terr_pulse", o_type_err, 1'b1);
        chk1("terr_no_beat", o_mem_valid, 1'b0);
        step(1);
        chk1("terr_clear", o_type_err, 1'b0);
        chk1("terr_no_beat2", o_mem_valid, 1'b0);
        send(3'b000, 32'h0000_4001, 32'h0000_0066);
        step(1);
        chk_beat("after_terr", 32'h0000_4000, 4'b0010, 32'h0000_6600);
        step(3);

        // Capacity: DEPTH queued plus one in the output register, then drain.
        i_mem_ready = 1'b0;
        for (int k = 0; k < 5; k++) send(3'b011, 32'h0000_6000 + 32'(k * 16), 32'(k + 1));
        chk1("cap_ready_low", o_ready, 1'b0);
        chk1("cap_valid_held", o_mem_valid, 1'b1);
        i_mem_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge i_clk);
            chk1("drain_consecutive", o_mem_valid, 1'b1);
        end
        @(negedge i_clk);
        chk1("drain_empty", o_empty, 1'b1);
        chk1("drain_valid_low", o_mem_valid, 1'b0);
        step(2);

        // Reset while a beat is stalled with stores queued behind it.
`ifdef STORE_SPLIT_EN
        send(3'b011, 32'h0000_7002, 32'hCAFE_F00D);
        step(1);
        step(1);
        i_mem_ready = 1'b0;
        chk_beat("stall_b1", 32'h0000_7004, 4'b0011, 32'h0000_CAFE);
`else
        i_mem_ready = 1'b0;
        send(3'b011, 32'h0000_7000, 32'hCAFE_F00D);
        step(1);
        chk_beat("stall_b0", 32'h0000_7000, 4'b1111, 32'hCAFE_F00D);
`endif
        send(3'b000, 32'h0000_7100, 32'h0000_0001);
        send(3'b000, 32'h0000_7200, 32'h0000_0002);
        i_reset = 1'b1;
        step(1);
        i_reset = 1'b0;
        chk1("midrst_valid", o_mem_valid, 1'b0);
        chk1("midrst_empty", o_empty, 1'b1);
        chk1("midrst_ready", o_ready, 1'b1);
        i_mem_ready = 1'b1;
        step(10);

        // Randomized traffic with backpressure and occasional reset.
        for (int c = 0; c < 3000; c++) begin
            int r;
            r = $urandom_range(0, 9);
            i_valid = ($urandom_range(0, 2) != 0);
            if (r < 3) i_type = 3'b000;
            else if (r < 6) i_type = 3'b001;
            else if (r < 9) i_type = 3'b011;
            else i_type = 3'($urandom_range(4, 7));
            if ($urandom_range(0, 7) == 0) i_addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            else i_addr = $urandom;
            i_data = $urandom;
            i_mem_ready = ($urandom_range(0, 3) != 0);
            i_reset = ($urandom_range(0, 299) == 0);
            step(1);
        end
        i_valid = 1'b0; i_reset = 1'b0; i_mem_ready = 1'b1;
        for (int k = 0; k < 100 && !(o_empty && q.size() == 0); k++) step(1);
        chk1("final_drained", o_empty, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
